// File: rtl/fn_eval_pkg.sv
// Shared command codes, FSM state encoding and STATUS word layout for the
// function-evaluation command front-end.
package fn_eval_pkg;

  localparam logic [1:0] CMD_CLEAR  = 2'd0;
  localparam logic [1:0] CMD_GO     = 2'd1;
  localparam logic [1:0] CMD_READ   = 2'd2;
  localparam logic [1:0] CMD_STATUS = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE_A = 3'd1,
    ST_ISSUE_B = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_RESP    = 3'd4
  } state_e;

  // STATUS word: err in the MSB, ovf just below it, outstanding in the LSBs.
  localparam int STATUS_ERR_FROM_MSB = 0;
  localparam int STATUS_OVF_FROM_MSB = 1;

endpackage

// File: rtl/fn_eval_credit_counter.sv
// Up/down counter of operands in flight in the evaluation core.
module fn_eval_credit_counter #(
  parameter int MAX_COUNT = 16,
  parameter int CW        = $clog2(MAX_COUNT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (inc && !dec) begin
      count_reg <= count_reg + CW'(1);
    end else if (dec && !inc) begin
      count_reg <= count_reg - CW'(1);
    end
  end

  assign count = count_reg;
  assign full  = (count_reg == CW'(MAX_COUNT));
  assign empty = (count_reg == '0);

endmodule

// File: rtl/fn_eval_accum_ctrl.sv
// Command front-end: issues operands to the evaluation core, accumulates the
// returned results and answers CLEAR / GO / READ / STATUS commands.
module fn_eval_accum_ctrl
  import fn_eval_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int RES_WIDTH       = 22,
  parameter int ACC_WIDTH       = 32,
  parameter int NUM_OPS         = 2,
  parameter int MAX_OUTSTANDING = 16,
  parameter int SATURATE        = 1,
  parameter int N_WIDTH         = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_en,
  input  logic                  start,
  input  logic [N_WIDTH-1:0]    n,
  input  logic [DATA_WIDTH-1:0] dataa,
  input  logic [DATA_WIDTH-1:0] datab,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  done,
  output logic                  op_valid,
  input  logic                  op_ready,
  output logic [DATA_WIDTH-1:0] op_data,
  input  logic                  res_valid,
  input  logic [RES_WIDTH-1:0]  res_data
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  state_e                  state_reg, state_next;
  logic [N_WIDTH-1:0]      cmd_reg;
  logic [DATA_WIDTH-1:0]   a_reg, b_reg, result_reg;
  logic [ACC_WIDTH-1:0]    acc_reg, acc_next;
  logic                    ovf_reg, err_reg;
  logic [CW-1:0]           outstanding;
  logic                    full, empty;
  logic                    sample, accept, ret_ok, ret_err, drain_exit;
  logic                    add_ovf;
  logic [ACC_WIDTH:0]      sum_ext;
  logic [DATA_WIDTH-1:0]   acc_sat, status_word;
  logic [ACC_WIDTH-DATA_WIDTH:0] acc_top;

  assign sample     = (state_reg == ST_IDLE) && clk_en && start;
  assign accept     = op_valid && op_ready;
  assign ret_ok     = res_valid && !empty;
  assign ret_err    = res_valid && empty;
  assign drain_exit = (state_reg == ST_DRAIN) && empty;

  fn_eval_credit_counter #(
    .MAX_COUNT (MAX_OUTSTANDING),
    .CW        (CW)
  ) u_credit (
    .clk   (clk),
    .rst   (rst),
    .inc   (accept),
    .dec   (ret_ok),
    .count (outstanding),
    .full  (full),
    .empty (empty)
  );

  // One guard bit above the accumulator exposes signed overflow of the add.
  assign sum_ext = {acc_reg[ACC_WIDTH-1], acc_reg}
                 + {{(ACC_WIDTH + 1 - RES_WIDTH){res_data[RES_WIDTH-1]}}, res_data};
  assign add_ovf = sum_ext[ACC_WIDTH] != sum_ext[ACC_WIDTH-1];

  always_comb begin
    acc_next = sum_ext[ACC_WIDTH-1:0];
    if (add_ovf && (SATURATE != 0)) begin
      acc_next = sum_ext[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                    : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
  end

  assign acc_top = acc_reg[ACC_WIDTH-1:DATA_WIDTH-1];
  assign acc_sat = ((&acc_top) || !(|acc_top)) ? acc_reg[DATA_WIDTH-1:0]
                 : (acc_reg[ACC_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                         : {1'b0, {(DATA_WIDTH-1){1'b1}}});

  always_comb begin
    status_word = '0;
    status_word[CW-1:0] = outstanding;
    status_word[DATA_WIDTH-1-STATUS_ERR_FROM_MSB] = err_reg;
    status_word[DATA_WIDTH-1-STATUS_OVF_FROM_MSB] = ovf_reg;
  end

  always_comb begin
    state_next = state_reg;
    op_valid   = 1'b0;
    op_data    = '0;
    done       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (sample) begin
          if (n == N_WIDTH'(CMD_GO))          state_next = ST_ISSUE_A;
          else if (n == N_WIDTH'(CMD_STATUS)) state_next = ST_RESP;
          else                                state_next = ST_DRAIN;
        end
      end
      ST_ISSUE_A: begin
        op_valid = !full;
        op_data  = a_reg;
        if (!full && op_ready) state_next = (NUM_OPS == 2) ? ST_ISSUE_B : ST_RESP;
      end
      ST_ISSUE_B: begin
        op_valid = !full;
        op_data  = b_reg;
        if (!full && op_ready) state_next = ST_RESP;
      end
      ST_DRAIN: begin
        if (empty) state_next = ST_RESP;
      end
      ST_RESP: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= ST_IDLE;
      cmd_reg    <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
      acc_reg    <= '0;
      ovf_reg    <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (sample) begin
        cmd_reg <= n;
        a_reg   <= dataa;
        b_reg   <= datab;
        if (n == N_WIDTH'(CMD_STATUS)) result_reg <= status_word;
      end
      // CLEAR wins over anything returned on its completing edge.
      if (drain_exit && (cmd_reg == N_WIDTH'(CMD_CLEAR))) begin
        acc_reg    <= '0;
        ovf_reg    <= 1'b0;
        err_reg    <= 1'b0;
        result_reg <= '0;
      end else begin
        if (ret_ok) begin
          acc_reg <= acc_next;
          if (add_ovf) ovf_reg <= 1'b1;
        end
        if (ret_err) err_reg <= 1'b1;
        if (drain_exit) result_reg <= acc_sat;
      end
    end
  end

  assign result = result_reg;

endmodule
